// File: rtl/apb_master_mux.sv
// apb_master_mux: APB4 master with a valid/ready command front end and an
// address-decoded fan-out to NUM_SLAVES peripherals. Each accepted command
// runs one SETUP/ACCESS transfer on the slave picked by
// cmd_addr[SLV_LSB +: SEL_W] and returns a single-cycle response pulse.
// Indices with no slave behind them finish through a one-cycle decode-error
// state, so PSEL stays low for them.
// Optional macro APB_TIMEOUT_EN: bounds the ACCESS wait to TIMEOUT_CYCLES
// cycles. When it fires, the response reports rsp_err and rsp_timeout.
module apb_master_mux #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int SLV_LSB        = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESET,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_write,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic [DATA_WIDTH-1:0]            cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]          cmd_strb,
  input  logic [2:0]                       cmd_prot,
  output logic                             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             rsp_timeout,
  output logic                             busy,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [DATA_WIDTH/8-1:0]          PSTRB,
  output logic [2:0]                       PPROT,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DERR   = 2'd3
  } state_t;

  state_t                  state_reg, state_next;
  logic [SEL_W-1:0]        idx_reg, idx_next;
  logic [NUM_SLAVES-1:0]   psel_reg, psel_next;
  logic                    penable_reg, penable_next;
  logic                    pwrite_reg, pwrite_next;
  logic [ADDR_WIDTH-1:0]   paddr_reg, paddr_next;
  logic [DATA_WIDTH-1:0]   pwdata_reg, pwdata_next;
  logic [STRB_W-1:0]       pstrb_reg, pstrb_next;
  logic [2:0]              pprot_reg, pprot_next;
  logic                    rsp_valid_reg, rsp_valid_next;
  logic [DATA_WIDTH-1:0]   rsp_rdata_reg, rsp_rdata_next;
  logic                    rsp_err_reg, rsp_err_next;
  logic                    rsp_timeout_reg, rsp_timeout_next;

  logic [SEL_W-1:0]        cmd_idx;
  logic                    cmd_idx_ok;
  logic                    accept;
  logic [NUM_SLAVES-1:0]   cmd_sel;
  logic [NUM_SLAVES-1:0]   cur_sel;
  logic [DATA_WIDTH-1:0]   rdata_masked [NUM_SLAVES];
  logic [DATA_WIDTH-1:0]   slave_rdata;
  logic                    slave_ready;
  logic                    slave_err;

`ifdef APB_TIMEOUT_EN
  logic [15:0]             wait_reg, wait_next;
`else
  // The limit only matters when the timeout build is selected.
  logic                    unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_LIM;
`endif

  // Slave index field of the incoming address. Indices past the last
  // slave (non-power-of-two NUM_SLAVES) take the decode-error path.
  assign cmd_idx    = cmd_addr[SLV_LSB +: SEL_W];
  assign cmd_idx_ok = (32'(cmd_idx) < 32'(NUM_SLAVES));

  // The PRESET term keeps cmd_ready low for as long as reset is held.
  assign cmd_ready = (state_reg == IDLE) && !PRESET;
  assign accept    = cmd_valid && cmd_ready;

  // One-hot decode of the incoming and latched index, plus AND-masking of
  // each slave's read data so that only the selected slice survives the OR.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
      assign cmd_sel[gi]      = (cmd_idx == SEL_W'(gi));
      assign cur_sel[gi]      = (idx_reg == SEL_W'(gi));
      assign rdata_masked[gi] = PRDATA[gi*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{cur_sel[gi]}};
    end
  endgenerate

  // OR-reduce the masked read-data slices into the muxed return value.
  always_comb begin
    slave_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      slave_rdata = slave_rdata | rdata_masked[k];
    end
  end

  assign slave_ready = |(PREADY & cur_sel);
  assign slave_err   = |(PSLVERR & cur_sel);

  // Next-state and next-output logic. APB payload outputs hold by default,
  // and the response fields default to an idle (all-zero) cycle.
  always_comb begin
    state_next       = state_reg;
    idx_next         = idx_reg;
    psel_next        = psel_reg;
    penable_next     = penable_reg;
    pwrite_next      = pwrite_reg;
    paddr_next       = paddr_reg;
    pwdata_next      = pwdata_reg;
    pstrb_next       = pstrb_reg;
    pprot_next       = pprot_reg;
    rsp_valid_next   = 1'b0;
    rsp_rdata_next   = '0;
    rsp_err_next     = 1'b0;
    rsp_timeout_next = 1'b0;
`ifdef APB_TIMEOUT_EN
    wait_next        = wait_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (accept) begin
          idx_next = cmd_idx;
          if (cmd_idx_ok) begin
            state_next   = SETUP;
            psel_next    = cmd_sel;
            penable_next = 1'b0;
            paddr_next   = cmd_addr;
            pwrite_next  = cmd_write;
            pwdata_next  = cmd_wdata;
            pstrb_next   = cmd_write ? cmd_strb : '0;
            pprot_next   = cmd_prot;
          end else begin
            // No slave to address: the payload outputs keep their old values.
            state_next = DERR;
          end
        end
      end

      SETUP: begin
        state_next   = ACCESS;
        penable_next = 1'b1;
`ifdef APB_TIMEOUT_EN
        wait_next    = '0;
`endif
      end

      ACCESS: begin
        if (slave_ready) begin
          state_next     = IDLE;
          psel_next      = '0;
          penable_next   = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_err_next   = slave_err;
          rsp_rdata_next = (!pwrite_reg && !slave_err) ? slave_rdata : '0;
        end
`ifdef APB_TIMEOUT_EN
        // A ready slave on the same edge wins over the limit.
        else if ((wait_reg + 16'd1) == TIMEOUT_LIM) begin
          state_next       = IDLE;
          psel_next        = '0;
          penable_next     = 1'b0;
          rsp_valid_next   = 1'b1;
          rsp_err_next     = 1'b1;
          rsp_timeout_next = 1'b1;
        end else begin
          wait_next = wait_reg + 16'd1;
        end
`endif
      end

      DERR: begin
        state_next     = IDLE;
        rsp_valid_next = 1'b1;
        rsp_err_next   = 1'b1;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and registered outputs. Reset drops any transfer in progress
  // without a response.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_reg       <= IDLE;
      idx_reg         <= '0;
      psel_reg        <= '0;
      penable_reg     <= 1'b0;
      pwrite_reg      <= 1'b0;
      paddr_reg       <= '0;
      pwdata_reg      <= '0;
      pstrb_reg       <= '0;
      pprot_reg       <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_err_reg     <= 1'b0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      psel_reg        <= psel_next;
      penable_reg     <= penable_next;
      pwrite_reg      <= pwrite_next;
      paddr_reg       <= paddr_next;
      pwdata_reg      <= pwdata_next;
      pstrb_reg       <= pstrb_next;
      pprot_reg       <= pprot_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_rdata_reg   <= rsp_rdata_next;
      rsp_err_reg     <= rsp_err_next;
      rsp_timeout_reg <= rsp_timeout_next;
    end
  end

`ifdef APB_TIMEOUT_EN
  // Wait-state counter for the ACCESS phase.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wait_reg <= '0;
    end else begin
      wait_reg <= wait_next;
    end
  end
`endif

  assign busy        = (state_reg != IDLE);
  assign PSEL        = psel_reg;
  assign PENABLE     = penable_reg;
  assign PADDR       = paddr_reg;
  assign PWRITE      = pwrite_reg;
  assign PWDATA      = pwdata_reg;
  assign PSTRB       = pstrb_reg;
  assign PPROT       = pprot_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_rdata   = rsp_rdata_reg;
  assign rsp_err     = rsp_err_reg;
  assign rsp_timeout = rsp_timeout_reg;

endmodule
